// File: rtl/uart_result_framer.sv
// uart_result_framer: frames a multi-byte result as HEADER, payload LSB-first, CSUM for a byte-wide UART transmitter
module uart_result_framer #(
  parameter int NUM_BYTES = 4,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BYTES*8-1:0] result_data,
  input  logic                   result_valid,
  output logic                   result_ready,
  output logic [7:0]             uart_data,
  output logic                   send_uart_data,
  input  logic                   uart_data_sent,
  output logic                   busy,
  output logic [15:0]            frames_sent
);
  localparam int IW = $clog2(NUM_BYTES + 2);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state;
  logic [IW-1:0] idx, nxt;
  logic [NUM_BYTES*8-1:0] payload;
  logic [7:0] csum;
  logic [(NUM_BYTES+2)*8-1:0] frame;
  always_comb begin
    csum = '0;
    for (int k = 0; k < NUM_BYTES; k++) csum = csum + payload[8*k +: 8];
  end
  // Byte k of the frame sits at frame[8k +: 8], so the index addresses it directly
  assign frame = {csum, payload, HEADER};
  assign nxt = idx + 1'b1;
  assign result_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      payload <= '0;
      frames_sent <= '0;
      uart_data <= 8'h00;
      send_uart_data <= 1'b0;
    end else begin
      case (state)
        IDLE: if (result_valid) begin
          payload <= result_data;
          idx <= '0;
          uart_data <= HEADER;
          send_uart_data <= 1'b1;
          state <= SEND;
        end
        SEND: begin
          send_uart_data <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (uart_data_sent) begin
          if (idx == IW'(NUM_BYTES + 1)) begin
            frames_sent <= frames_sent + 16'd1;
            state <= IDLE;
          end else begin
            idx <= nxt;
            uart_data <= frame[{nxt, 3'b000} +: 8];
            send_uart_data <= 1'b1;
            state <= SEND;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_result_framer.sv
// tb_uart_result_framer: table-driven frames checked through an expected-byte scoreboard
module tb_uart_result_framer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] result_data = '0;
  logic result_valid = 1'b0;
  logic result_ready;
  logic [7:0] uart_data;
  logic send_uart_data;
  logic uart_data_sent = 1'b0;
  logic busy;
  logic [15:0] frames_sent;
  int pass_cnt = 0;
  int total = 0;
  logic [15:0] exp_frames = '0;
  logic [7:0] q[$];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  csum;
    int          gap;
    bit          spurious;
  } vec_t;
  vec_t vecs[5];

  uart_result_framer #(.NUM_BYTES(4), .HEADER(8'hA5)) dut (
    .clock(clock), .reset(reset), .result_data(result_data), .result_valid(result_valid),
    .result_ready(result_ready), .uart_data(uart_data), .send_uart_data(send_uart_data),
    .uart_data_sent(uart_data_sent), .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clock = ~clock;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", n, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && send_uart_data) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_strobe: got strobe with data %h, required no strobe", uart_data);
      end else check("strobed_byte", {24'b0, uart_data}, {24'b0, q.pop_front()});
    end
  end

  task automatic run_frame(input logic [31:0] d, input logic [7:0] cs, input int gap, input bit spurious,
                           input int abort_at, input bit hold_valid, input logic [31:0] next_d);
    logic [7:0] e[6];
    e[0] = 8'hA5;
    for (int k = 0; k < 4; k++) e[k+1] = d[8*k +: 8];
    e[5] = cs;
    for (int i = 0; i < 6; i++) q.push_back(e[i]);
    result_data = d;
    result_valid = 1'b1;
    @(negedge clock);
    check("accept_latency", {31'b0, send_uart_data}, 32'd1);
    if (hold_valid) result_data = next_d;
    else result_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      if (b == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        check("abort_strobe", {31'b0, send_uart_data}, 32'd0);
        check("abort_data", {24'b0, uart_data}, 32'h00);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_frames", {16'b0, frames_sent}, {16'b0, exp_frames});
        @(negedge clock);
        check("abort_ready", {31'b0, result_ready}, 32'd1);
        repeat (5) @(negedge clock);
        return;
      end
      if (spurious) uart_data_sent = 1'b1;
      @(negedge clock);
      uart_data_sent = 1'b0;
      if (gap > 100) begin
        result_valid = 1'b1;
        result_data = 32'h5A5A5A5A;
      end
      repeat (gap) @(negedge clock);
      check("wait_stable", {24'b0, uart_data}, {24'b0, e[b]});
      check("wait_ready_low", {31'b0, result_ready}, 32'd0);
      if (gap > 100) result_valid = 1'b0;
      uart_data_sent = 1'b1;
      @(negedge clock);
      uart_data_sent = 1'b0;
      if (b < 5) check("sent_latency", {31'b0, send_uart_data}, 32'd1);
      else begin
        exp_frames = exp_frames + 16'd1;
        check("ready_after_frame", {31'b0, result_ready}, 32'd1);
        check("busy_after_frame", {31'b0, busy}, 32'd0);
        check("frames_sent", {16'b0, frames_sent}, {16'b0, exp_frames});
      end
    end
    check("queue_drained", q.size(), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h04030201, 8'h0A, 0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 8'hFC, 3, 1'b0};
    vecs[2] = '{32'h12345678, 8'h14, 1, 1'b1};
    vecs[3] = '{32'h80808080, 8'h00, 2, 1'b0};
    vecs[4] = '{32'hDEADBEEF, 8'h38, 0, 1'b1};
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_uart_data", {24'b0, uart_data}, 32'h00);
    check("rst_strobe", {31'b0, send_uart_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, result_ready}, 32'd1);
    check("rst_frames", {16'b0, frames_sent}, 32'd0);
    run_frame(32'h04030201, 8'h0A, 0, 1'b0, 2, 1'b0, 32'h0);
    run_frame(32'h11223344, 8'hAA, 0, 1'b0, -1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) run_frame(vecs[i].data, vecs[i].csum, vecs[i].gap, vecs[i].spurious, -1, 1'b0, 32'h0);
    run_frame(32'h04030201, 8'h0A, 500, 1'b0, -1, 1'b0, 32'h0);
    repeat (3) begin
      uart_data_sent = 1'b1;
      @(negedge clock);
      uart_data_sent = 1'b0;
      @(negedge clock);
    end
    check("idle_sent_busy", {31'b0, busy}, 32'd0);
    check("idle_sent_ready", {31'b0, result_ready}, 32'd1);
    check("idle_sent_frames", {16'b0, frames_sent}, {16'b0, exp_frames});
    run_frame(32'hA1B2C3D4, 8'hEA, 1, 1'b0, -1, 1'b1, 32'h01010101);
    run_frame(32'h01010101, 8'h04, 0, 1'b0, -1, 1'b0, 32'h0);
    force dut.frames_sent = 16'hFFFF;
    #1 release dut.frames_sent;
    exp_frames = 16'hFFFF;
    @(negedge clock);
    check("preload_frames", {16'b0, frames_sent}, 32'h0000FFFF);
    run_frame(32'h00000000, 8'h00, 0, 1'b0, -1, 1'b0, 32'h0);
    check("wrap_frames", {16'b0, frames_sent}, 32'h00000000);
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/uart_result_framer.md
Name: uart_result_framer

Overview:
Upstream feeder for the UART byte transmitter. Accepts one multi-byte detection result per valid/ready handshake and serializes it as a framed byte stream: header byte, payload bytes LSB-first, then an 8-bit checksum. It drives the transmitter's byte/strobe input and paces itself on the transmitter's one-cycle "byte sent" pulse. It sits between the result-producing logic and the UART transmitter.

Parameters:
NUM_BYTES, 4, payload bytes per frame; legal range 1..16
HEADER, 8'hA5, constant first byte of every frame

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
result_data  input  NUM_BYTES*8  payload; byte k = result_data[8k+7:8k]
result_valid  input  1  producer has a result
result_ready  output  1  framer can accept a result
uart_data  output  8  byte presented to the transmitter
send_uart_data  output  1  one-cycle strobe: transmit uart_data
uart_data_sent  input  1  one-cycle pulse from the transmitter: byte finished
busy  output  1  high while a frame is in flight
frames_sent  output  16  count of completed frames; wraps at 16'hFFFF->0

Behaviour:
- Frame length is NUM_BYTES+2 bytes: HEADER, byte0..byte(NUM_BYTES-1), CSUM.
- CSUM is the sum of the payload bytes mod 256. HEADER is excluded from the sum.
- State machine states: IDLE, SEND, WAIT.
- IDLE:
  - result_ready=1, busy=0.
  - If result_valid is high at an edge: capture result_data into an internal register, clear byte index to 0, go to SEND.
- SEND (exactly one cycle):
  - send_uart_data=1; uart_data = byte selected by the index.
  - Index 0 selects HEADER, index 1..NUM_BYTES select payload byte index-1, index NUM_BYTES+1 selects CSUM.
  - Go to WAIT.
- WAIT:
  - send_uart_data=0; uart_data holds the same value (the transmitter latches on the strobe edge, so the value must stay stable until sent).
  - On uart_data_sent=1:
    - If index == NUM_BYTES+1: increment frames_sent and go to IDLE.
    - Otherwise: increment index and go to SEND.
- busy=1 and result_ready=0 in SEND and WAIT.
- Latency:
  - Result accepted at edge T → send_uart_data high during cycle T+1.
  - uart_data_sent sampled at edge E → next strobe high during cycle E+1.
  - The next frame can be accepted at the first edge after returning to IDLE.
- send_uart_data never asserts twice without an intervening uart_data_sent. It never asserts in IDLE.
- uart_data_sent seen in IDLE or SEND is ignored and leaves no side effects.
- The captured payload is unaffected by changes on result_data after acceptance.
- CSUM is computed from the captured register, not from live inputs.
- Reset values:
  - state=IDLE, index=0, captured payload=0, frames_sent=0.
  - uart_data=8'h00, send_uart_data=0, busy=0.
  - result_ready=1 from the first cycle after reset deasserts.
- Reset mid-frame: the frame is abandoned with no further strobes and frames_sent is not incremented. Any byte already handed to the transmitter is allowed to finish downstream.
- Widths:
  - Index counter is wide enough for NUM_BYTES+1.
  - Checksum accumulates in 8 bits, discarding carries.

Test Plan:
- NUM_BYTES=4; accept result 32'h04030201 → uart_data sequence A5,01,02,03,04,0A; one strobe per byte; frames_sent 0→1; result_ready returns to 1 after the 6th uart_data_sent.
- Payload 32'hFFFFFFFF → checksum byte FC (1020 mod 256); sequence A5,FF,FF,FF,FF,FC.
- Hold uart_data_sent low for 500 cycles in WAIT → exactly one strobe, uart_data stable, result_valid ignored (result_ready=0). Then pulse sent → next byte strobed the following cycle.
- Spurious uart_data_sent pulses while IDLE, and in the same cycle as a SEND strobe → no index advance, no extra strobes; the frame completes normally with 6 bytes.
- Assert reset after the 3rd byte's strobe → send_uart_data=0, uart_data=00, busy=0, frames_sent unchanged. The next accepted result 32'h11223344 yields A5,44,33,22,11,AA from index 0.
- Back-to-back: result_valid held high with two distinct results → second accepted only in IDLE after frame 1 completes; frames_sent=2. Preload frames_sent to FFFF via 65535 frames, or force, then complete one frame → wraps to 0000.
